seg_display_ctrl: RTL and testbench

Board-facing display stage sitting directly downstream of the MIPS core in `main`. It consumes the core's `pc` and `result` words plus the board switches and keys. It drives the 2-digit multiplexed seven-segment display (`com`, `segs`) and the 4 LEDs. Any byte of either word can be paged onto the display, and the displayed value can be frozen while the core keeps running.

---
 rtl/seg_display_ctrl.sv | 149 ++++++++++++++
 tb/tb_seg_display_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// Two-digit multiplexed hex display of a selectable byte of the core's pc/result words,
// with debounced byte paging keys, one-hot byte LEDs and a freeze switch.
module seg_display_ctrl #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic [31:0] result,
    input  logic [1:0]  sw,
    input  logic [1:0]  key,
    output logic [1:0]  com,
    output logic [7:0]  segs,
    output logic [3:0]  leds
);
    localparam int SW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW_W-1:0] SCAN_MAX = SW_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sw_meta_reg, sw_sync_reg;
    logic [1:0]      key_meta_reg, key_sync_reg;
    logic [1:0]      press_evt;
    logic [1:0]      idx_reg, idx_next;
    logic [31:0]     held_reg;
    logic [SW_W-1:0] scan_cnt_reg;
    logic            dig_reg;
    logic [1:0]      com_reg;
    logic [7:0]      segs_reg;
    logic [7:0]      cur_byte;
    logic [3:0]      cur_nibble;
    logic [6:0]      hex_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_reg  <= 2'b00;
            sw_sync_reg  <= 2'b00;
            key_meta_reg <= 2'b11;
            key_sync_reg <= 2'b11;
        end else begin
            sw_meta_reg  <= sw;
            sw_sync_reg  <= sw_meta_reg;
            key_meta_reg <= key;
            key_sync_reg <= key_meta_reg;
        end
    end

    // Level flips on the D-th consecutive mismatching cycle; the press pulse is registered alongside it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_db
            logic [DB_W-1:0] cnt_reg;
            logic            level_reg;
            logic            press_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b1;
                    press_reg <= 1'b0;
                end else begin
                    press_reg <= 1'b0;
                    if (key_sync_reg[gi] == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_MAX) begin
                        cnt_reg   <= '0;
                        level_reg <= key_sync_reg[gi];
                        press_reg <= ~key_sync_reg[gi];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press_evt[gi] = press_reg;
        end
    endgenerate

    always_comb begin
        idx_next = idx_reg;
        case (press_evt)
            2'b01:   idx_next = idx_reg + 2'd1;
            2'b10:   idx_next = idx_reg - 2'd1;
            2'b11:   idx_next = 2'd0;
            default: idx_next = idx_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg      <= 2'd0;
            held_reg     <= 32'd0;
            scan_cnt_reg <= '0;
            dig_reg      <= 1'b0;
        end else begin
            idx_reg <= idx_next;
            if (!sw_sync_reg[1])
                held_reg <= sw_sync_reg[0] ? result : pc;
            if (scan_cnt_reg == SCAN_MAX) begin
                scan_cnt_reg <= '0;
                dig_reg      <= ~dig_reg;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
        end
    end

    assign cur_byte   = held_reg[8*idx_reg +: 8];
    assign cur_nibble = dig_reg ? cur_byte[7:4] : cur_byte[3:0];

    always_comb begin
        hex_code = 7'h7F;
        case (cur_nibble)
            4'h0: hex_code = 7'h40;
            4'h1: hex_code = 7'h79;
            4'h2: hex_code = 7'h24;
            4'h3: hex_code = 7'h30;
            4'h4: hex_code = 7'h19;
            4'h5: hex_code = 7'h12;
            4'h6: hex_code = 7'h02;
            4'h7: hex_code = 7'h78;
            4'h8: hex_code = 7'h00;
            4'h9: hex_code = 7'h10;
            4'hA: hex_code = 7'h08;
            4'hB: hex_code = 7'h03;
            4'hC: hex_code = 7'h46;
            4'hD: hex_code = 7'h21;
            4'hE: hex_code = 7'h06;
            4'hF: hex_code = 7'h0E;
            default: hex_code = 7'h7F;
        endcase
    end

    // Decimal point on digit 0 marks a frozen display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            com_reg  <= 2'b11;
            segs_reg <= 8'hFF;
        end else begin
            com_reg  <= dig_reg ? 2'b01 : 2'b10;
            segs_reg <= {~(~dig_reg & sw_sync_reg[1]), hex_code};
        end
    end

    assign com  = com_reg;
    assign segs = segs_reg;
    assign leds = 4'b0001 << idx_reg;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with a short scan period and debounce interval.
module tb_seg_display_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, result;
    logic [1:0]  sw, key;
    logic [1:0]  com;
    logic [7:0]  segs;
    logic [3:0]  leds;

    int checks   = 0;
    int failures = 0;

    seg_display_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .result(result),
        .sw(sw), .key(key), .com(com), .segs(segs), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Wait (bounded) until the requested digit is lit, then return its segments.
    task automatic get_digit(input int d, output logic [7:0] s);
        logic [1:0] want;
        want = (d == 1) ? 2'b01 : 2'b10;
        s = 8'hxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (com === want) begin
                s = segs;
                return;
            end
        end
        failures++;
        $display("FAIL digit%0d_timeout observed=com %b expected=com %b", d, com, want);
    endtask

    task automatic show(input string tag, input logic [7:0] d1, input logic [7:0] d0);
        logic [7:0] s;
        get_digit(1, s);
        check({tag, "_d1"}, {24'd0, s}, {24'd0, d1});
        get_digit(0, s);
        check({tag, "_d0"}, {24'd0, s}, {24'd0, d0});
    endtask

    // Clean press held for 12 cycles, then released long enough to debounce the release.
    task automatic press(input logic [1:0] mask);
        key = ~mask;
        repeat (12) @(negedge clk);
        key = 2'b11;
        repeat (12) @(negedge clk);
    endtask

    task automatic run_len(input string tag);
        logic [1:0] first;
        int n;
        first = com;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (com !== first) break;
        end
        first = com;
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (com !== first) break;
            n++;
        end
        check(tag, n, 4);
    endtask

    initial begin
        rst_n  = 1'b0;
        pc     = 32'h12345678;
        result = 32'h0;
        sw     = 2'b00;
        key    = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_com", {30'd0, com}, 32'h3);
        check("rst_segs", {24'd0, segs}, 32'hFF);
        check("rst_leds", {28'd0, leds}, 32'h1);

        // First edge after release shows digit 0 of the cleared held word.
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_com", {30'd0, com}, 32'h2);
        check("first_segs", {24'd0, segs}, 32'hC0);

        run_len("scan_run_a");
        run_len("scan_run_b");
        show("pc_b0", 8'hF8, 8'h80);
        check("leds_idx0", {28'd0, leds}, 32'h1);

        press(2'b01);
        check("leds_p1", {28'd0, leds}, 32'h2);
        press(2'b01);
        check("leds_p2", {28'd0, leds}, 32'h4);
        show("pc_b2", 8'hB0, 8'h99);
        press(2'b01);
        check("leds_p3", {28'd0, leds}, 32'h8);
        show("pc_b3", 8'hF9, 8'hA4);
        press(2'b01);
        check("leds_wrap", {28'd0, leds}, 32'h1);

        // Bounces of 3 cycles never reach the 8-cycle debounce interval.
        for (int i = 0; i < 5; i++) begin
            key = 2'b10;
            repeat (3) @(negedge clk);
            key = 2'b11;
            repeat (3) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check("bounce_leds", {28'd0, leds}, 32'h1);
        key = 2'b10;
        repeat (40) @(negedge clk);
        check("hold_leds", {28'd0, leds}, 32'h2);
        key = 2'b11;
        repeat (12) @(negedge clk);

        press(2'b10);
        check("k1_dec", {28'd0, leds}, 32'h1);
        press(2'b10);
        check("k1_wrap", {28'd0, leds}, 32'h8);
        press(2'b11);
        check("both_keys", {28'd0, leds}, 32'h1);

        sw     = 2'b01;
        result = 32'hDEADBEEF;
        repeat (4) @(negedge clk);
        show("res_b0", 8'h86, 8'h8E);
        sw = 2'b11;
        repeat (4) @(negedge clk);
        result = 32'h0;
        sw     = 2'b10;
        repeat (10) @(negedge clk);
        show("frozen", 8'h86, 8'h0E);
        sw = 2'b00;
        repeat (4) @(negedge clk);
        show("unfrozen", 8'hF8, 8'h80);

        press(2'b01);
        press(2'b01);
        check("leds_idx2", {28'd0, leds}, 32'h4);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_com", {30'd0, com}, 32'h3);
        check("async_segs", {24'd0, segs}, 32'hFF);
        check("async_leds", {28'd0, leds}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        show("post_rst", 8'hF8, 8'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
